// File: rtl/pipelined_funnel_shifter.sv
// Two-stage pipelined shifter/rotator/funnel with valid/ready on both sides.
// Every op is mapped onto one right funnel shift of {hi,lo}; left ops bit-reverse around it.
module pipelined_funnel_shifter #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_hi,
  input  logic [WIDTH-1:0] in_lo,
  input  logic [SHW-1:0]   in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  // S1 applies amount bits [SHW-1:LO_BITS], S2 applies [LO_BITS-1:0].
  localparam int LO_BITS = SHW / 2;
  // Residual shift after S1 is < 2**LO_BITS, so only this many low bits can still reach the result.
  localparam int WW      = WIDTH + (1 << LO_BITS) - 1;

  typedef enum logic [2:0] {
    OP_SLL    = 3'd0,
    OP_SRL    = 3'd1,
    OP_SRA    = 3'd2,
    OP_ROL    = 3'd3,
    OP_ROR    = 3'd4,
    OP_FUNNEL = 3'd5,
    OP_RSV6   = 3'd6,
    OP_RSV7   = 3'd7
  } op_e;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    for (int i = 0; i < WIDTH; i++) bit_rev[i] = x[WIDTH-1-i];
  endfunction

  logic               s1_valid;
  op_e                s1_op;
  logic [LO_BITS-1:0] s1_amt;
  logic [WW-1:0]      s1_win;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // s1_lv[k] holds the funnel word with all amount bits >= k already applied.
  logic [2*WIDTH-1:0] s1_lv [LO_BITS:SHW];

  always_comb begin
    // NOTE: every always_comb target gets a value on every path (default arm here), so no latch is inferred.
    case (op_e'(in_op))
      OP_SLL:    s1_lv[SHW] = {{WIDTH{1'b0}}, bit_rev(in_lo)};
      OP_SRL:    s1_lv[SHW] = {{WIDTH{1'b0}}, in_lo};
      OP_SRA:    s1_lv[SHW] = {{WIDTH{in_lo[WIDTH-1]}}, in_lo};
      OP_ROL:    s1_lv[SHW] = {bit_rev(in_lo), bit_rev(in_lo)};
      OP_ROR:    s1_lv[SHW] = {in_lo, in_lo};
      OP_FUNNEL: s1_lv[SHW] = {in_hi, in_lo};
      default:   s1_lv[SHW] = '0;
    endcase
    for (int k = SHW; k > LO_BITS; k--)
      s1_lv[k-1] = in_amt[k-1] ? (s1_lv[k] >> (1 << (k-1))) : s1_lv[k];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      // NOTE: the datapath registers are cleared along with the valid bits so no stale operand survives reset.
      s1_valid <= 1'b0;
      s1_op    <= OP_SLL;
      s1_amt   <= '0;
      s1_win   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= op_e'(in_op);
        s1_amt <= in_amt[LO_BITS-1:0];
        s1_win <= s1_lv[LO_BITS][WW-1:0];
      end
    end
  end

  logic [WW-1:0]    s2_lv [0:LO_BITS];
  logic [WIDTH-1:0] s2_res;
  logic             s2_err;

  always_comb begin
    s2_lv[LO_BITS] = s1_win;
    for (int k = LO_BITS; k > 0; k--)
      s2_lv[k-1] = s1_amt[k-1] ? (s2_lv[k] >> (1 << (k-1))) : s2_lv[k];
    s2_res = s2_lv[0][WIDTH-1:0];
    s2_err = 1'b0;
    case (s1_op)
      OP_SLL, OP_ROL: s2_res = bit_rev(s2_lv[0][WIDTH-1:0]);
      OP_RSV6, OP_RSV7: begin
        s2_res = '0;
        s2_err = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_res;
        out_err  <= s2_err;
      end
    end
  end

endmodule

// File: doc/pipelined_funnel_shifter.md
PIPELINED_FUNNEL_SHIFTER -- requirements
Module: pipelined_funnel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data width. WIDTH SHALL be a power of two and at least 8.
REQ-002 SHALL have derived parameter SHW = log2(WIDTH), meaning the shift-amount width; it SHALL NOT be overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: request present.
REQ-006 SHALL have port in_ready, output, 1 bit: request accepted this cycle when in_valid is also high.
REQ-007 SHALL have port in_op, input, 3 bits: operation select (see REQ-013).
REQ-008 SHALL have port in_hi, input, WIDTH bits: upper funnel word; used by FUNNEL only.
REQ-009 SHALL have port in_lo, input, WIDTH bits: operand, and lower funnel word.
REQ-010 SHALL have port in_amt, input, SHW bits: shift amount, 0..WIDTH-1.
REQ-011 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_data (output, WIDTH bits) and out_err (output, 1 bit): the result channel.

Function
REQ-012 A request SHALL transfer on in_valid&&in_ready; a result SHALL transfer on out_valid&&out_ready.
REQ-013 in_op encoding:
- 000 SLL: zero-fill left shift.
- 001 SRL: zero-fill right shift.
- 010 SRA: sign-fill right shift.
- 011 ROL: rotate left.
- 100 ROR: rotate right.
- 101 FUNNEL: out_data = low WIDTH bits of ({in_hi,in_lo} >> in_amt).
- 110, 111: reserved.
REQ-014 in_amt = 0 SHALL return in_lo unchanged for all valid ops, including FUNNEL.
REQ-015 Reserved ops SHALL produce out_data = 0 and out_err = 1. out_err SHALL be 0 for all valid ops.
REQ-016 The shift SHALL be a log-shifter of SHW mux levels, split over two register stages:
- S1 registers the result of the upper ceil(SHW/2) amount bits, plus the op, the remaining amount bits and a valid bit.
- S2 applies the remaining levels and registers out_data, out_err and out_valid.
REQ-017 Latency SHALL be exactly 2 cycles: a request accepted at edge N has its result at out_valid from edge N+2 when no stall occurs.
REQ-018 Throughput SHALL be one request per cycle while out_ready stays high.
REQ-019 S2 SHALL advance when !out_valid || out_ready. S1 SHALL advance when !s1_valid || S2 advances.
REQ-020 in_ready SHALL equal the S1 advance condition; it is combinational from out_ready and state only, never from in_valid.
REQ-021 While out_valid && !out_ready, out_data and out_err SHALL hold stable.
REQ-022 Under a stall, no request SHALL be lost, duplicated or reordered, and the pipeline SHALL hold at most 2 requests.
REQ-023 When accept and drain occur in the same cycle on a full pipeline, both SHALL take effect; no bubble is inserted.
REQ-024 The ops SHALL be related as follows:
- ROL by k SHALL equal ROR by (WIDTH-k) mod WIDTH.
- SRA SHALL replicate in_lo[WIDTH-1] into all vacated bits.
- FUNNEL with in_hi = in_lo SHALL equal ROR.
REQ-025 When in_valid is low, the operand inputs SHALL be ignored.

Reset
REQ-026 While rst_n = 0 at a clock edge, all of the following SHALL be cleared: s1_valid = 0, out_valid = 0, out_data = 0, out_err = 0, and all S1 data registers = 0.
REQ-027 in_ready SHALL read 1 in the first cycle after rst_n rises.
REQ-028 Reset asserted mid-operation SHALL discard every in-flight request; no result for it SHALL appear after reset.
REQ-029 Inputs sampled during reset SHALL NOT be accepted.

Verification (WIDTH = 32)
REQ-030 SLL, in_lo = 0x00000001, amt = 31, out_ready = 1 -> out_data = 0x80000000, out_err = 0, out_valid exactly 2 cycles after accept.
REQ-031 Single-op checks, each with out_ready = 1:
- SRA 0x80000000 by 4 -> 0xF8000000.
- SRL 0x80000000 by 4 -> 0x08000000.
- ROR 0x12345678 by 8 -> 0x78123456.
- ROL 0x12345678 by 8 -> 0x34567812.
REQ-032 FUNNEL checks:
- hi = 0x000000FF, lo = 0x00000000, amt = 4 -> 0xF0000000.
- Same operands, amt = 0 -> 0x00000000.
REQ-033 Backpressure: 4 back-to-back SLL requests of 0x1 by 0,1,2,3, with out_ready low for 5 cycles after the first result -> in_ready drops after 2 accepts; results 0x1, 0x2, 0x4, 0x8 arrive in order, none missing, with out_data held during the stall.
REQ-034 op = 110, in_lo = 0xFFFFFFFF -> out_data = 0x00000000, out_err = 1, followed by a valid SLL with out_err = 0.
REQ-035 rst_n low for 1 cycle while 2 requests are in flight -> out_valid = 0 the next cycle, no stale result ever emitted, in_ready = 1 after release.
